// File: rtl/npc_dmem_responder.sv
// ---------------------------------------------------------------------------
// npc_dmem_responder
//   Memory-side responder for the NPC core's load/store port. Accepts one
//   read or write request at a time over a valid/ready handshake and models
//   a fixed access latency against an internal 64-bit-wide SRAM. It then
//   returns a response that is held until the core takes it.
//
//   Writes commit to the SRAM on the acceptance edge, merged per byte lane.
//   Reads sample the SRAM on the edge that raises rsp_valid_o.
//   Out-of-range accesses return rsp_err_o=1 with zero data after the same
//   latency as a normal access.
//
// Optional feature (macro NPC_DMEM_RAND_LATENCY_EN):
//   When the macro is defined, an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1,
//   seed 8'hA5) adds 0..3 extra wait cycles per request. The extra wait is
//   lfsr[1:0] before the step, and the LFSR steps once per accepted request.
//   When the macro is undefined, the latency is fixed at LATENCY.
//
// Ports:
//   clk_i        clock, all state changes on posedge
//   rst_i        synchronous active-high reset
//   req_valid_i  request present
//   req_ready_o  responder can accept a request
//   req_addr_i   byte address; bits [2:0] ignored
//   req_wen_i    1 = write, 0 = read
//   req_wdata_i  write data
//   req_wmask_i  byte-lane write enables
//   rsp_valid_o  response present
//   rsp_ready_i  core accepts response
//   rsp_rdata_o  read data (0 for writes and errors)
//   rsp_err_o    address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*8)
// ---------------------------------------------------------------------------
module npc_dmem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    input  logic        req_wen_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // Holds LATENCY-1 (max 14) plus up to 3 extra random cycles.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [63:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wen_q;
    logic               err_q;

    logic [63:0]        mem_q [DEPTH_WORDS];

    logic [63:0]        off_d;
    logic               in_range_d;
    logic [IDX_W-1:0]   idx_d;
    logic               accept_d;
    logic [CNT_W-1:0]   extra_d;
    logic [CNT_W-1:0]   cnt_load_d;

    // Range decode: the subtraction wraps for addresses below BASE_ADDR,
    // so the explicit lower-bound compare is what rejects them.
    assign off_d      = req_addr_i - BASE_ADDR;
    assign in_range_d = (req_addr_i >= BASE_ADDR) &&
                        (off_d[63:3] < 61'(DEPTH_WORDS));
    assign idx_d      = off_d[IDX_W+2:3];

    // req_ready_q is only ever high in IDLE.
    assign accept_d   = req_valid_i && req_ready_q;

`ifdef NPC_DMEM_RAND_LATENCY_EN
    logic [7:0] lfsr_q;

    assign extra_d = CNT_W'(lfsr_q[1:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 8'hA5;
        end else if (accept_d) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
`else
    assign extra_d = '0;
`endif

    assign cnt_load_d = CNT_W'(LATENCY - 1) + extra_d;

    // Write commit at the acceptance edge. A reset on that same edge wins,
    // so the request is not accepted and nothing is written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept_d && req_wen_i && in_range_d) begin
            for (int b = 0; b < 8; b++) begin
                if (req_wmask_i[b]) begin
                    mem_q[idx_d][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM. The counter reaching zero in WAIT means the next
    // edge raises the response, so rsp_valid rises LATENCY(+extra) edges
    // after acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            idx_q       <= '0;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        req_ready_q <= 1'b0;
                        idx_q       <= idx_d;
                        wen_q       <= req_wen_i;
                        err_q       <= !in_range_d;
                        cnt_q       <= cnt_load_d;
                        state_q     <= WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (wen_q || err_q) ? 64'd0 : mem_q[idx_q];
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_npc_dmem_responder.sv
module tb_npc_dmem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    npc_dmem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_wen_i  (req_wen),
        .req_wdata_i(req_wdata),
        .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: word index -> contents, only for words whose
    // value is fully known.
    logic [63:0] mdl [longint];
    logic [7:0]  ref_lfsr;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < 64'(DEPTH) * 64'd8);
    endfunction

    // Expected latency of the next accepted request.
    task automatic next_lat(output int e);
`ifdef NPC_DMEM_RAND_LATENCY_EN
        e = LAT + int'(ref_lfsr[1:0]);
        ref_lfsr = {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
`else
        e = LAT;
`endif
    endtask

    // Apply one request to the reference memory and return the response it should produce.
    task automatic model_op(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wmask, output logic [63:0] erd,
                            output logic eerr, output bit known);
        longint      k;
        logic [63:0] w;
        eerr  = !in_rng(addr);
        erd   = 64'd0;
        known = 1'b1;
        k     = longint'((addr - BASE) >> 3);
        if (!eerr) begin
            if (wen) begin
                if (mdl.exists(k) || wmask == 8'hFF) begin
                    w = mdl.exists(k) ? mdl[k] : 64'd0;
                    for (int b = 0; b < 8; b++)
                        if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
                    mdl[k] = w;
                end
            end else if (mdl.exists(k)) begin
                erd = mdl[k];
            end else begin
                known = 1'b0;
            end
        end
    endtask

    // One full transaction: handshake, latency check, hold, release.
    task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input int hold, input bit use_model,
                           input string nm, output logic [63:0] got_rd, output logic got_err);
        int          n;
        int          lat;
        int          elat;
        logic [63:0] erd;
        logic        eerr;
        bit          known;
        logic [63:0] first_rd;
        got_rd  = 64'd0;
        got_err = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " req_ready before accept"}, 64'(req_ready), 64'd1);
        if (!req_ready) return;
        model_op(wen, addr, wdata, wmask, erd, eerr, known);
        next_lat(elat);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        @(posedge clk); #1;
        // Keep a garbage write on the bus while busy; it must be ignored.
        req_wen   = 1'b1;
        req_addr  = BASE + 64'(8 * $urandom_range(0, 15));
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'hFF;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        if (!rsp_valid) begin
            req_valid = 1'b0;
            return;
        end
        got_rd   = rsp_rdata;
        got_err  = rsp_err;
        first_rd = rsp_rdata;
        if (use_model) begin
            chk({nm, " err"}, 64'(rsp_err), 64'(eerr));
            if (known) chk({nm, " rdata"}, rsp_rdata, erd);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, " hold valid/ready/err"}, {61'd0, rsp_valid, req_ready, rsp_err},
                {61'd0, 1'b1, 1'b0, got_err});
            chk({nm, " hold rdata"}, rsp_rdata, first_rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({nm, " after release valid/ready/err"}, {61'd0, rsp_valid, req_ready, rsp_err},
            {61'd0, 1'b0, 1'b1, 1'b0});
        chk({nm, " after release rdata"}, rsp_rdata, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] a;
        int          r;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
        ref_lfsr = 8'hA5;

        tbl.push_back('{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0});
        tbl.push_back('{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0});
        tbl.push_back('{1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0});
        tbl.push_back('{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0});
        tbl.push_back('{1'b0, 64'h8000_0013, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0});
        tbl.push_back('{1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1});
        tbl.push_back('{1'b0, 64'h8000_8000, 64'd0, 8'h00, 64'd0, 1'b1});
        tbl.push_back('{1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0});
        tbl.push_back('{1'b1, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1});
        tbl.push_back('{1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0});
        tbl.push_back('{1'b1, 64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'd0, 1'b0});
        tbl.push_back('{1'b0, 64'h8000_7FF8, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0});
        tbl.push_back('{1'b1, 64'h8000_0010, 64'h5555_5555_5555_5555, 8'h00, 64'd0, 1'b0});
        tbl.push_back('{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid/ready/err", {61'd0, rsp_valid, req_ready, rsp_err}, 64'd0);
        chk("reset rdata", rsp_rdata, 64'd0);
        rst = 1'b0;
        chk("ready low until first edge out of reset", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready after reset release", 64'(req_ready), 64'd1);

        // Directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            run_txn(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, 0, 1'b0,
                    $sformatf("vec%0d", i), rd, er);
            chk($sformatf("vec%0d err", i), 64'(er), 64'(tbl[i].eerr));
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].erd);
        end

        // Response held under backpressure
        run_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 5, 1'b1, "backpressure", rd, er);
        chk("backpressure rdata", rd, 64'h1122_3344_AAAA_AAAA);

        // Reset one cycle after accepting a read
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-txn reset valid/ready/err", {61'd0, rsp_valid, req_ready, rsp_err}, 64'd0);
        chk("mid-txn reset rdata", rsp_rdata, 64'd0);
        rst = 1'b0;
        ref_lfsr = 8'hA5;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("no response for dropped read", 64'(rsp_valid), 64'd0);
            if (c == 0) chk("ready first cycle after reset", 64'(req_ready), 64'd1);
        end
        run_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 1'b1, "post-reset read", rd, er);
        chk("SRAM survives reset", rd, 64'h1122_3344_AAAA_AAAA);

        // Prefill a window of words, then random traffic against the model
        for (int w = 0; w < 16; w++)
            run_txn(1'b1, BASE + 64'(8 * w), {$urandom, $urandom}, 8'hFF, 0, 1'b1,
                    "prefill", rd, er);
        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                a = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
            else if (r == 1)
                a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 63));
            else
                a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            run_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
                    int'($urandom_range(0, 2)), 1'b1, $sformatf("rand%0d", t), rd, er);
        end

`ifdef NPC_DMEM_RAND_LATENCY_EN
        for (int t = 0; t < 16; t++)
            run_txn(1'b0, BASE + 64'(8 * (t % 16)), 64'd0, 8'h00, 0, 1'b1,
                    $sformatf("lfsr%0d", t), rd, er);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
